// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory.
// Each transaction runs IDLE -> ACCESS -> RESP, with an ack on RESP.
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int FIXED_PRI = 0
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Req0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] Wdata0,
  input  logic          W0,
  output logic          Ack0,
  output logic [DW-1:0] Rdata0,
  input  logic          Req1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] Wdata1,
  input  logic          W1,
  output logic          Ack1,
  output logic [DW-1:0] Rdata1,
  output logic [AW-1:0] Mem_ADDR,
  output logic [DW-1:0] Mem_DOUT,
  output logic          Mem_W,
  input  logic [DW-1:0] Mem_DIN,
  output logic          Busy,
  output logic          Owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          w_q, w_d;
  logic          owner_q, owner_d;
  logic          pick1;

  // On a tie in round-robin mode the port that did not win last time goes.
  assign pick1 = Req1 &&
    (!Req0 || ((FIXED_PRI == 0) && !owner_q));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      w_q     <= 1'b0;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      w_q     <= w_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    w_d     = w_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        w_d = 1'b0;
        if (Req0 || Req1) begin
          state_d = ACCESS;
          owner_d = pick1;
          addr_d  = pick1 ? Addr1  : Addr0;
          dout_d  = pick1 ? Wdata1 : Wdata0;
          w_d     = pick1 ? W1     : W0;
        end
      end
      ACCESS: begin
        w_d     = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        w_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign Mem_ADDR = addr_q;
  assign Mem_DOUT = dout_q;
  assign Mem_W    = w_q;
  assign Owner    = owner_q;
  assign Busy     = (state_q != IDLE);
  assign Ack0     = (state_q == RESP) && !owner_q;
  assign Ack1     = (state_q == RESP) &&  owner_q;
  assign Rdata0   = Mem_DIN;
  assign Rdata1   = Mem_DIN;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances
// share stimulus; each drives its own behavioural memory.
module tb_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [15:0] Addr0 = '0, Addr1 = '0;
  logic [15:0] Wdata0 = '0, Wdata1 = '0;
  logic        W0 = 1'b0, W1 = 1'b0;

  logic        ack0_r, ack1_r, ack0_f, ack1_f;
  logic [15:0] rd0_r, rd1_r, rd0_f, rd1_f;
  logic [15:0] maddr_r, mdout_r, maddr_f, mdout_f;
  logic        mw_r, mw_f;
  logic [15:0] din_r, din_f;
  logic        busy_r, busy_f, own_r, own_f;

  logic [15:0] mem_r [256];
  logic [15:0] mem_f [256];

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  mem_arbiter #(.AW(16), .DW(16), .FIXED_PRI(0)) u_rr (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Addr0(Addr0), .Wdata0(Wdata0), .W0(W0),
    .Ack0(ack0_r), .Rdata0(rd0_r),
    .Req1(Req1), .Addr1(Addr1), .Wdata1(Wdata1), .W1(W1),
    .Ack1(ack1_r), .Rdata1(rd1_r),
    .Mem_ADDR(maddr_r), .Mem_DOUT(mdout_r), .Mem_W(mw_r),
    .Mem_DIN(din_r), .Busy(busy_r), .Owner(own_r)
  );

  mem_arbiter #(.AW(16), .DW(16), .FIXED_PRI(1)) u_fp (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Addr0(Addr0), .Wdata0(Wdata0), .W0(W0),
    .Ack0(ack0_f), .Rdata0(rd0_f),
    .Req1(Req1), .Addr1(Addr1), .Wdata1(Wdata1), .W1(W1),
    .Ack1(ack1_f), .Rdata1(rd1_f),
    .Mem_ADDR(maddr_f), .Mem_DOUT(mdout_f), .Mem_W(mw_f),
    .Mem_DIN(din_f), .Busy(busy_f), .Owner(own_f)
  );

  // External synchronous memories, cleared by reset for known contents.
  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) mem_r[i] <= '0;
      din_r <= '0;
    end else begin
      if (mw_r) mem_r[maddr_r[7:0]] <= mdout_r;
      din_r <= mem_r[maddr_r[7:0]];
    end
  end

  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) mem_f[i] <= '0;
      din_f <= '0;
    end else begin
      if (mw_f) mem_f[maddr_f[7:0]] <= mdout_f;
      din_f <= mem_f[maddr_f[7:0]];
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Req0 = 0; Req1 = 0; W0 = 0; W1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    Req0 = 1; Req1 = 1; W0 = 1; Addr0 = 16'h55; Wdata0 = 16'h77;
    tick();
    tick();
    Reset = 1;
    tick();
    checks++;
    if ({busy_r, mw_r, ack0_r, ack1_r} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl_rr: got %b want 0000",
               {busy_r, mw_r, ack0_r, ack1_r});
    end
    checks++;
    if ({maddr_r, mdout_r} !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus_rr: got %h want 0", {maddr_r, mdout_r});
    end
    checks++;
    if (own_r !== 1'b1 || own_f !== 1'b1) begin
      errors++;
      $display("FAIL reset_owner: got %b%b want 11", own_r, own_f);
    end
    checks++;
    if ({busy_f, mw_f, ack0_f, ack1_f, maddr_f} !== 20'h0) begin
      errors++;
      $display("FAIL reset_fp: got %h want 0",
               {busy_f, mw_f, ack0_f, ack1_f, maddr_f});
    end
    Reset = 0;
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    Req0 = 1; W0 = 1; Addr0 = 16'h0010; Wdata0 = 16'h00A5;
    tick();
    checks++;
    if ({mw_r, maddr_r, mdout_r, busy_r, ack0_r} !== {1'b1, 16'h0010, 16'h00A5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wr_access: got w=%b a=%h d=%h busy=%b ack=%b want 1 0010 00a5 1 0",
               mw_r, maddr_r, mdout_r, busy_r, ack0_r);
    end
    tick();
    checks++;
    if ({mw_r, busy_r, ack0_r, ack1_r} !== 4'b0110) begin
      errors++;
      $display("FAIL wr_resp: got %b want 0110", {mw_r, busy_r, ack0_r, ack1_r});
    end
    Req0 = 0; W0 = 0;
    tick();
    checks++;
    if ({mw_r, busy_r, ack0_r, ack1_r} !== 4'b0000) begin
      errors++;
      $display("FAIL wr_idle: got %b want 0000", {mw_r, busy_r, ack0_r, ack1_r});
    end
  endtask

  task automatic test_read();
    Req1 = 1; W1 = 0; Addr1 = 16'h0010; Wdata1 = 16'hFFFF;
    tick();
    checks++;
    if ({mw_r, maddr_r, own_r} !== {1'b0, 16'h0010, 1'b1}) begin
      errors++;
      $display("FAIL rd_access: got w=%b a=%h own=%b want 0 0010 1",
               mw_r, maddr_r, own_r);
    end
    tick();
    checks++;
    if ({ack1_r, ack0_r, mw_r, rd1_r} !== {3'b100, 16'h00A5}) begin
      errors++;
      $display("FAIL rd_resp: got ack1=%b ack0=%b w=%b rd=%h want 1 0 0 00a5",
               ack1_r, ack0_r, mw_r, rd1_r);
    end
    Req1 = 0;
    tick();
  endtask

  task automatic test_tie();
    int q_r[$];
    int q_f[$];
    int exp_r[4];
    exp_r = '{0, 1, 0, 1};
    do_reset();
    Req0 = 1; Req1 = 1; W0 = 0; W1 = 0;
    Addr0 = 16'h3; Addr1 = 16'h4;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if ((ack0_r && ack1_r) || (ack0_f && ack1_f)) begin
        errors++;
        $display("FAIL tie_both_ack: got rr=%b%b fp=%b%b want not 11",
                 ack0_r, ack1_r, ack0_f, ack1_f);
      end
      if (ack0_r) q_r.push_back(0);
      if (ack1_r) q_r.push_back(1);
      if (ack0_f) q_f.push_back(0);
      if (ack1_f) q_f.push_back(1);
    end
    idle_inputs();
    tick();
    checks++;
    if (q_r.size() != 4 || q_f.size() != 4) begin
      errors++;
      $display("FAIL tie_count: got rr=%0d fp=%0d want 4 4",
               q_r.size(), q_f.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_r[i] != exp_r[i]) begin
          errors++;
          $display("FAIL tie_rr_order[%0d]: got %0d want %0d", i, q_r[i], exp_r[i]);
        end
        checks++;
        if (q_f[i] != 0) begin
          errors++;
          $display("FAIL tie_fp_order[%0d]: got %0d want 0", i, q_f[i]);
        end
      end
    end
  endtask

  task automatic test_withdraw();
    logic [15:0] old30;
    do_reset();
    old30 = mem_r[8'h30];
    Req0 = 1; W0 = 1; Addr0 = 16'h0020; Wdata0 = 16'h1234;
    tick();
    Req0 = 0; Addr0 = 16'h0030; Wdata0 = 16'hBEEF; W0 = 0;
    tick();
    checks++;
    if ({ack0_r, maddr_r, mw_r} !== {1'b1, 16'h0020, 1'b0}) begin
      errors++;
      $display("FAIL wd_resp: got ack=%b a=%h w=%b want 1 0020 0",
               ack0_r, maddr_r, mw_r);
    end
    tick();
    tick();
    checks++;
    if (ack0_r !== 1'b0 || busy_r !== 1'b0) begin
      errors++;
      $display("FAIL wd_single_ack: got ack=%b busy=%b want 0 0", ack0_r, busy_r);
    end
    checks++;
    if (mem_r[8'h20] !== 16'h1234 || mem_r[8'h30] !== old30) begin
      errors++;
      $display("FAIL wd_mem: got m20=%h m30=%h want 1234 %h",
               mem_r[8'h20], mem_r[8'h30], old30);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Req1 = 1; W1 = 0; Addr1 = 16'h0044;
    tick();
    Reset = 1;
    tick();
    Reset = 0;
    checks++;
    if ({busy_r, mw_r, ack1_r, own_r} !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_state: got busy,w,ack1,own=%b want 0001",
               {busy_r, mw_r, ack1_r, own_r});
    end
    Req0 = 1; Req1 = 1; W0 = 0; W1 = 0;
    tick();
    checks++;
    if ({own_r, own_f, ack1_r, ack1_f} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_tie: got own=%b%b ack1=%b%b want 00 00",
               own_r, own_f, ack1_r, ack1_f);
    end
    tick();
    checks++;
    if ({ack0_r, ack1_r} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_ack: got %b want 10", {ack0_r, ack1_r});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [256];
    bit          pend0, pend1, w0, w1, win, last;
    logic [15:0] a0, a1, d0, d1, ea, ed;
    bit          ew;
    int          wait0, wait1;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    pend0 = 0; pend1 = 0; last = 1; wait0 = 0; wait1 = 0;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0; w0 = 0; w1 = 0;
    for (int t = 0; t < 60; t++) begin
      if (!pend0) begin
        pend0 = ($urandom_range(0, 2) != 0);
        a0 = 16'($urandom_range(0, 15));
        d0 = 16'($urandom);
        w0 = 1'($urandom_range(0, 1));
      end
      if (!pend1) begin
        pend1 = ($urandom_range(0, 2) != 0);
        a1 = 16'($urandom_range(0, 15));
        d1 = 16'($urandom);
        w1 = 1'($urandom_range(0, 1));
      end
      Req0 = pend0; Addr0 = a0; Wdata0 = d0; W0 = w0;
      Req1 = pend1; Addr1 = a1; Wdata1 = d1; W1 = w1;
      if (!pend0 && !pend1) begin
        tick();
        checks++;
        if (busy_r !== 1'b0 || mw_r !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle t=%0d: got busy=%b w=%b want 0 0", t, busy_r, mw_r);
        end
        continue;
      end
      win = (pend0 && pend1) ? !last : pend1;
      ea = win ? a1 : a0;
      ed = win ? d1 : d0;
      ew = win ? w1 : w0;
      if (pend0 && win) wait1 = wait1;
      if (pend1 && !win) wait1++;
      if (pend0 && win) wait0++;
      checks++;
      if (wait0 > 1 || wait1 > 1) begin
        errors++;
        $display("FAIL rnd_starve t=%0d: got waits %0d %0d want <=1", t, wait0, wait1);
      end
      tick();
      checks++;
      if ({busy_r, own_r, maddr_r, mdout_r, mw_r} !== {1'b1, win, ea, ed, ew}) begin
        errors++;
        $display("FAIL rnd_grant t=%0d: got own=%b a=%h d=%h w=%b want %b %h %h %b",
                 t, own_r, maddr_r, mdout_r, mw_r, win, ea, ed, ew);
      end
      if ($urandom_range(0, 1) == 1) begin
        if (win) begin
          Addr1 = 16'($urandom); Wdata1 = 16'($urandom); Req1 = 1'($urandom_range(0, 1));
        end else begin
          Addr0 = 16'($urandom); Wdata0 = 16'($urandom); Req0 = 1'($urandom_range(0, 1));
        end
      end
      tick();
      checks++;
      if ({ack0_r, ack1_r, mw_r} !== {!win, win, 1'b0}) begin
        errors++;
        $display("FAIL rnd_ack t=%0d: got ack=%b%b w=%b want %b%b 0",
                 t, ack0_r, ack1_r, mw_r, !win, win);
      end
      if (!ew) begin
        checks++;
        if ((win ? rd1_r : rd0_r) !== ref_mem[ea[7:0]]) begin
          errors++;
          $display("FAIL rnd_rdata t=%0d: got %h want %h",
                   t, (win ? rd1_r : rd0_r), ref_mem[ea[7:0]]);
        end
      end else begin
        ref_mem[ea[7:0]] = ed;
      end
      if (win) begin pend1 = 0; wait1 = 0; end
      else begin pend0 = 0; wait0 = 0; end
      last = win;
      Req0 = pend0; Addr0 = a0; Wdata0 = d0; W0 = w0;
      Req1 = pend1; Addr1 = a1; Wdata1 = d1; W1 = w1;
      tick();
      checks++;
      if ({busy_r, ack0_r, ack1_r} !== 3'b000) begin
        errors++;
        $display("FAIL rnd_back t=%0d: got %b want 000", t, {busy_r, ack0_r, ack1_r});
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    Addr0 = '0; Addr1 = '0;
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
